// File: rtl/lpm_ticket_sched.sv
// lpm_ticket_sched: in-order retirement scheduler for the LPM lookup pipeline.
// Lookups take a sequence ticket on entry. They may complete in any order, and
// results leave toward the output queue strictly in ticket order.
module lpm_ticket_sched #(
  parameter int TICKET_W = 4,
  parameter int DATA_W   = 32
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                allocateTicket__ENA,
  output logic                allocateTicket__RDY,
  output logic [TICKET_W-1:0] getTicket,
  input  logic                complete__ENA,
  input  logic [TICKET_W-1:0] complete_ticket,
  input  logic [DATA_W-1:0]   complete_data,
  output logic                complete__RDY,
  output logic                out__ENA,
  output logic [TICKET_W-1:0] out_ticket,
  output logic [DATA_W-1:0]   out_data,
  input  logic                out__RDY,
  output logic [TICKET_W:0]   count,
  output logic                err
);

  localparam int D = 1 << TICKET_W;
  // Table depth expressed at the width of the outstanding counter.
  localparam logic [TICKET_W:0] DEPTH = {1'b1, {TICKET_W{1'b0}}};

  logic [TICKET_W-1:0] head_r;
  logic [TICKET_W-1:0] tail_r;
  logic [TICKET_W:0]   count_r;
  logic [D-1:0]        done_r;
  logic [DATA_W-1:0]   data_r [D];
  logic                err_r;

  logic                alloc_rdy_s;
  logic                alloc_fire_s;
  logic                alloc_err_s;
  logic [TICKET_W-1:0] cpl_offset_s;
  logic                cpl_in_window_s;
  logic                cpl_valid_s;
  logic                cpl_err_s;
  logic                head_done_s;
  logic                retire_fire_s;

  // Handshake decode; readiness is derived only from registered state.
  always_comb begin
    alloc_rdy_s     = 1'b0;
    alloc_fire_s    = 1'b0;
    alloc_err_s     = 1'b0;
    cpl_offset_s    = {TICKET_W{1'b0}};
    cpl_in_window_s = 1'b0;
    cpl_valid_s     = 1'b0;
    cpl_err_s       = 1'b0;
    head_done_s     = 1'b0;
    retire_fire_s   = 1'b0;

    alloc_rdy_s  = (count_r != DEPTH);
    alloc_fire_s = allocateTicket__ENA & alloc_rdy_s;
    alloc_err_s  = allocateTicket__ENA & ~alloc_rdy_s;

    // A ticket is outstanding when its distance from head (mod D) is below count.
    cpl_offset_s    = complete_ticket - head_r;
    cpl_in_window_s = ({1'b0, cpl_offset_s} < count_r);
    if (complete__ENA) begin
      cpl_valid_s = cpl_in_window_s & ~done_r[complete_ticket];
      cpl_err_s   = ~cpl_valid_s;
    end else begin
      cpl_valid_s = 1'b0;
      cpl_err_s   = 1'b0;
    end

    head_done_s   = done_r[head_r];
    retire_fire_s = head_done_s & out__RDY;
  end

  // Pointer, occupancy, completion flags and sticky error state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_r  <= {TICKET_W{1'b0}};
      tail_r  <= {TICKET_W{1'b0}};
      count_r <= {(TICKET_W+1){1'b0}};
      done_r  <= {D{1'b0}};
      err_r   <= 1'b0;
    end else begin
      if (alloc_fire_s) begin
        tail_r <= tail_r + {{(TICKET_W-1){1'b0}}, 1'b1};
      end

      if (retire_fire_s) begin
        head_r <= head_r + {{(TICKET_W-1){1'b0}}, 1'b1};
      end

      case ({alloc_fire_s, retire_fire_s})
        2'b10:   count_r <= count_r + {{TICKET_W{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{TICKET_W{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase

      // A valid completion can never target a done head, so clear and set
      // never collide on the same entry.
      if (retire_fire_s) begin
        done_r[head_r] <= 1'b0;
      end
      if (cpl_valid_s) begin
        done_r[complete_ticket] <= 1'b1;
      end

      if (alloc_err_s || cpl_err_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Result payload storage; written only by valid completions, never reset.
  always_ff @(posedge CLK) begin
    if (cpl_valid_s) begin
      data_r[complete_ticket] <= complete_data;
    end
  end

  // Output decode straight from registers so that reset is visible at once.
  always_comb begin
    allocateTicket__RDY = alloc_rdy_s;
    getTicket           = tail_r;
    complete__RDY       = 1'b1;
    out__ENA            = head_done_s;
    out_ticket          = head_r;
    out_data            = data_r[head_r];
    count               = count_r;
    err                 = err_r;
  end

endmodule

// File: tb/tb_lpm_ticket_sched.sv
// Directed bench for lpm_ticket_sched: reset, reorder, full/wrap,
// backpressure, protocol errors and a mid-operation reset.
module tb_lpm_ticket_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alloc_ena = 1'b0;
  logic        alloc_rdy;
  logic [3:0]  get_ticket;
  logic        cpl_ena = 1'b0;
  logic [3:0]  cpl_ticket = 4'd0;
  logic [31:0] cpl_data = 32'd0;
  logic        cpl_rdy;
  logic        out_ena;
  logic [3:0]  out_ticket;
  logic [31:0] out_data;
  logic        out_rdy = 1'b0;
  logic [4:0]  cnt;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;

  lpm_ticket_sched #(.TICKET_W(4), .DATA_W(32)) dut (
    .CLK                 (clk),
    .RST                 (rst),
    .allocateTicket__ENA (alloc_ena),
    .allocateTicket__RDY (alloc_rdy),
    .getTicket           (get_ticket),
    .complete__ENA       (cpl_ena),
    .complete_ticket     (cpl_ticket),
    .complete_data       (cpl_data),
    .complete__RDY       (cpl_rdy),
    .out__ENA            (out_ena),
    .out_ticket          (out_ticket),
    .out_data            (out_data),
    .out__RDY            (out_rdy),
    .count               (cnt),
    .err                 (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
  endtask

  task automatic alloc_n(input int n);
    alloc_ena = 1'b1;
    repeat (n) tick();
    alloc_ena = 1'b0;
  endtask

  task automatic complete(input logic [3:0] t, input logic [31:0] d);
    cpl_ena    = 1'b1;
    cpl_ticket = t;
    cpl_data   = d;
    tick();
    cpl_ena    = 1'b0;
  endtask

  initial begin
    // ---- 1: reset state ----
    #3;
    check("rst_rdy", {63'd0, alloc_rdy}, 64'd1);
    check("rst_ticket", {60'd0, get_ticket}, 64'd0);
    check("rst_count", {59'd0, cnt}, 64'd0);
    check("rst_out_ena", {63'd0, out_ena}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("cpl_rdy", {63'd0, cpl_rdy}, 64'd1);
    tick();
    rst = 1'b0;
    tick();

    // ---- 2: out-of-order completion, in-order retirement ----
    out_rdy = 1'b1;
    alloc_n(3);
    check("reo_count", {59'd0, cnt}, 64'd3);
    check("reo_tail", {60'd0, get_ticket}, 64'd3);
    complete(4'd2, 32'hC);
    check("reo_wait_t2", {63'd0, out_ena}, 64'd0);
    cpl_ena = 1'b1; cpl_ticket = 4'd0; cpl_data = 32'hA;
    tick();
    // t1 completes in the same cycle t0 retires
    cpl_ticket = 4'd1; cpl_data = 32'hB;
    check("reo_ena0", {63'd0, out_ena}, 64'd1);
    check("reo_tk0", {60'd0, out_ticket}, 64'd0);
    check("reo_d0", {32'd0, out_data}, 64'hA);
    tick();
    cpl_ena = 1'b0;
    check("reo_ena1", {63'd0, out_ena}, 64'd1);
    check("reo_tk1", {60'd0, out_ticket}, 64'd1);
    check("reo_d1", {32'd0, out_data}, 64'hB);
    check("reo_cnt1", {59'd0, cnt}, 64'd2);
    tick();
    check("reo_tk2", {60'd0, out_ticket}, 64'd2);
    check("reo_d2", {32'd0, out_data}, 64'hC);
    tick();
    check("reo_idle", {63'd0, out_ena}, 64'd0);
    check("reo_cnt0", {59'd0, cnt}, 64'd0);
    check("reo_err", {63'd0, err}, 64'd0);

    // ---- 3: full table and wrap ----
    pulse_reset();
    alloc_ena = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("full_tk%0d", i), {60'd0, get_ticket}, 64'(i));
      tick();
    end
    alloc_ena = 1'b0;
    check("full_rdy", {63'd0, alloc_rdy}, 64'd0);
    check("full_count", {59'd0, cnt}, 64'd16);
    check("full_err0", {63'd0, err}, 64'd0);
    alloc_n(1);
    check("full_ovf_err", {63'd0, err}, 64'd1);
    check("full_ovf_cnt", {59'd0, cnt}, 64'd16);
    complete(4'd0, 32'h1234);
    check("full_ret_ena", {63'd0, out_ena}, 64'd1);
    check("full_still_full", {63'd0, alloc_rdy}, 64'd0);
    tick();
    check("full_rdy_back", {63'd0, alloc_rdy}, 64'd1);
    check("full_wrap_tk", {60'd0, get_ticket}, 64'd0);
    check("full_cnt15", {59'd0, cnt}, 64'd15);
    alloc_n(1);
    check("full_again", {59'd0, cnt}, 64'd16);
    // retire + allocate while full: allocate must be refused
    complete(4'd1, 32'h77);
    alloc_ena = 1'b1;
    tick();
    alloc_ena = 1'b0;
    check("full_ar_cnt", {59'd0, cnt}, 64'd15);
    check("full_ar_tail", {60'd0, get_ticket}, 64'd1);

    // ---- 4: backpressure ----
    out_rdy = 1'b0;
    pulse_reset();
    alloc_n(3);
    complete(4'd0, 32'h55);
    for (int i = 0; i < 5; i++) begin
      check("bp_ena", {63'd0, out_ena}, 64'd1);
      check("bp_data", {32'd0, out_data}, 64'h55);
      check("bp_tk", {60'd0, out_ticket}, 64'd0);
      tick();
    end
    check("bp_cnt3", {59'd0, cnt}, 64'd3);
    alloc_ena = 1'b1;
    out_rdy   = 1'b1;
    tick();
    alloc_ena = 1'b0;
    check("bp_ar_cnt", {59'd0, cnt}, 64'd3);
    check("bp_ar_tail", {60'd0, get_ticket}, 64'd4);
    check("bp_ar_head", {60'd0, out_ticket}, 64'd1);
    check("bp_ar_ena", {63'd0, out_ena}, 64'd0);
    check("bp_err", {63'd0, err}, 64'd0);

    // ---- 5: protocol errors ----
    out_rdy = 1'b0;
    pulse_reset();
    complete(4'd5, 32'hDEAD);
    check("err_stray", {63'd0, err}, 64'd1);
    check("err_stray_cnt", {59'd0, cnt}, 64'd0);
    check("err_stray_ena", {63'd0, out_ena}, 64'd0);
    tick();
    check("err_sticky", {63'd0, err}, 64'd1);
    pulse_reset();
    check("err_cleared", {63'd0, err}, 64'd0);
    alloc_n(2);
    complete(4'd1, 32'h111);
    check("dup_ok_err", {63'd0, err}, 64'd0);
    complete(4'd1, 32'h222);
    check("dup_err", {63'd0, err}, 64'd1);
    complete(4'd0, 32'hAA);
    out_rdy = 1'b1;
    check("dup_d0", {32'd0, out_data}, 64'hAA);
    tick();
    check("dup_tk1", {60'd0, out_ticket}, 64'd1);
    check("dup_d1", {32'd0, out_data}, 64'h111);
    tick();
    check("dup_cnt", {59'd0, cnt}, 64'd0);

    // ---- 6: reset in the middle of operation ----
    out_rdy = 1'b0;
    pulse_reset();
    alloc_n(4);
    complete(4'd0, 32'h10);
    complete(4'd1, 32'h11);
    check("mid_pre_ena", {63'd0, out_ena}, 64'd1);
    check("mid_pre_cnt", {59'd0, cnt}, 64'd4);
    rst = 1'b1;
    #1;
    check("mid_ena", {63'd0, out_ena}, 64'd0);
    check("mid_cnt", {59'd0, cnt}, 64'd0);
    check("mid_rdy", {63'd0, alloc_rdy}, 64'd1);
    check("mid_tk", {60'd0, get_ticket}, 64'd0);
    #1;
    rst = 1'b0;
    out_rdy = 1'b1;
    tick();
    check("mid_post_ena", {63'd0, out_ena}, 64'd0);
    check("mid_post_cnt", {59'd0, cnt}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
